// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI bus arbiter: FSM encoding and default watchdog limit.
// Imported by spi_bus_arbiter and rr_priority_picker.
package spi_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or above ptr_i,
// wrapping modulo NUM_REQ (works for non-power-of-two NUM_REQ).
module rr_priority_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    // Scan from farthest to nearest so the nearest hit to ptr_i wins.
    always_comb begin
        int pos;
        pos     = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req_i[pos]) begin
                idx_o   = IDX_W'(pos);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI engine among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int CS_W           = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*CS_W-1:0]   req_cs,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      eng_start,
    output logic [CS_W-1:0]           eng_cs,
    output logic [DATA_W-1:0]         eng_tx_data,
    output logic                      eng_abort,
    input  logic                      eng_done,
    input  logic [DATA_W-1:0]         eng_rx_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CS_W-1:0]   cs_q, cs_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              timeout_hit;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;

    // Watchdog counts WAIT cycles; held at zero elsewhere so it restarts on entry.
    always_comb begin
        cnt_d = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
        rsp_err_d = rsp_err_q;
        if (state_q == ST_WAIT && eng_done) begin
            rsp_err_d = 1'b0;
        end else if (timeout_hit) begin
            rsp_err_d = 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && !eng_done &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign eng_abort   = timeout_hit;
    assign rsp_err     = rsp_err_q;

    // Watchdog and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign eng_abort      = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // Sequencer next-state, request grant and latching.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cs_d       = cs_q;
        tx_d       = tx_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d = win_idx;
                    cs_d    = req_cs[win_idx*CS_W +: CS_W];
                    tx_d    = req_data[win_idx*DATA_W +: DATA_W];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    rsp_data_d = eng_rx_data;
                    state_d    = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ?
                           '0 : grant_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-hot response strobe for the granted requester.
    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    assign eng_start   = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign eng_cs      = cs_q;
    assign eng_tx_data = tx_q;
    assign rsp_data    = rsp_data_q;

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cs_q       <= '0;
            tx_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cs_q       <= cs_d;
            tx_q       <= tx_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (4 requesters).
// Timeout scenarios run only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 4096;
`endif
    localparam int SINGLE_LAT = (TO_CYC > 64) ? 40 : 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [7:0]  req_cs = '0;
    logic [127:0] req_data = '0;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        eng_start;
    logic [1:0]  eng_cs;
    logic [31:0] eng_tx_data;
    logic        eng_abort;
    logic        eng_done = 1'b0;
    logic [31:0] eng_rx_data = '0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    spi_bus_arbiter #(
        .NUM_REQ        (4),
        .DATA_W         (32),
        .CS_W           (2),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cs      (req_cs),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .eng_start   (eng_start),
        .eng_cs      (eng_cs),
        .eng_tx_data (eng_tx_data),
        .eng_abort   (eng_abort),
        .eng_done    (eng_done),
        .eng_rx_data (eng_rx_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stimulus only: one full transfer, returning what was observed.
    task automatic xfer(input logic [3:0] vld, input logic [31:0] rx,
                        input int lat, output logic [3:0] rdy,
                        output logic st, output logic [1:0] cs,
                        output logic [31:0] tx, output logic [3:0] rv,
                        output logic [31:0] rd, output logic re);
        @(negedge clk);
        req_valid = vld;
        #1 rdy = req_ready;
        @(negedge clk);
        st = eng_start;
        cs = eng_cs;
        tx = eng_tx_data;
        repeat (lat) @(negedge clk);
        eng_done = 1'b1;
        eng_rx_data = rx;
        @(negedge clk);
        eng_done = 1'b0;
        rv = rsp_valid;
        rd = rsp_data;
        re = rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cs,
             eng_tx_data, eng_abort, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%b rv=%b",
                     busy, rsp_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        logic [3:0]  rdy, rv;
        logic        st, re;
        logic [1:0]  cs;
        logic [31:0] tx, rd;
        logic [3:0]  exp;
        req_cs   = {2'd3, 2'd2, 2'd1, 2'd0};
        req_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        for (int i = 0; i < 8; i++) begin
            exp = 4'b0001 << (i % 4);
            xfer(4'b1111, 32'hC000_0000 + i, 3, rdy, st, cs, tx, rv, rd, re);
            n_checks++;
            if (rdy !== exp) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i, rdy, exp);
            end
            n_checks++;
            if (rv !== exp || rd !== 32'hC000_0000 + i) begin
                n_fail++;
                $display("FAIL contention_rsp[%0d]: got %b/%h want %b/%h",
                         i, rv, rd, exp, 32'hC000_0000 + i);
            end
            n_checks++;
            if (tx !== 32'hD000_0000 + (i % 4)) begin
                n_fail++;
                $display("FAIL contention_tx[%0d]: got %h", i, tx);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [3:0]  rdy, rv;
        logic        st, re;
        logic [1:0]  cs;
        logic [31:0] tx, rd;
        req_cs   = {2'd0, 2'd0, 2'd2, 2'd0};
        req_data = '0;
        req_data[63:32] = 32'hA5A5_0001;
        xfer(4'b0010, 32'h1234_5678, SINGLE_LAT, rdy, st, cs, tx, rv, rd, re);
        req_valid = '0;
        n_checks++;
        if (rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0010", rdy);
        end
        n_checks++;
        if (st !== 1'b1 || cs !== 2'd2 || tx !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL single_issue: got st=%b cs=%0d tx=%h want 1/2/a5a50001",
                     st, cs, tx);
        end
        n_checks++;
        if (rv !== 4'b0010 || rd !== 32'h1234_5678 || re !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got %b/%h/%b want 0010/12345678/0", rv, rd, re);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got rv=%b busy=%b want 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  rdy, rv;
        logic        st, re;
        logic [1:0]  cs;
        logic [31:0] tx, rd;
        xfer(4'b0100, 32'h0000_0022, 2, rdy, st, cs, tx, rv, rd, re);
        n_checks++;
        if (rdy !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_setup: got %b want 0100", rdy);
        end
        xfer(4'b1001, 32'h0000_0033, 2, rdy, st, cs, tx, rv, rd, re);
        n_checks++;
        if (rdy !== 4'b1000 || rv !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got %b/%b want 1000", rdy, rv);
        end
        xfer(4'b1001, 32'h0000_0044, 2, rdy, st, cs, tx, rv, rd, re);
        n_checks++;
        if (rdy !== 4'b0001 || rv !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_second: got %b/%b want 0001", rdy, rv);
        end
        req_valid = '0;
    endtask

    task automatic test_spurious_done();
        @(negedge clk);
        req_valid = '0;
        eng_done = 1'b1;
        eng_rx_data = 32'hDEAD_0000;
        @(negedge clk);
        eng_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL spurious_idle: got busy=%b rv=%b want 0/0000", busy, rsp_valid);
        end
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        eng_done = 1'b1;
        n_checks++;
        if (eng_start !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_issue: got start=%b want 1", eng_start);
        end
        @(negedge clk);
        eng_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1 || eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_wait: got rv=%b busy=%b want 0000/1", rsp_valid, busy);
        end
        @(negedge clk);
        eng_done = 1'b1;
        eng_rx_data = 32'h0BAD_F00D;
        @(negedge clk);
        eng_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL spurious_rsp: got %b/%h want 0100/0badf00d", rsp_valid, rsp_data);
        end
        @(negedge clk);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        bit seen;
        @(negedge clk);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        k = 0;
        seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (eng_abort === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || k !== 16) begin
            n_fail++;
            $display("FAIL timeout_abort_time: got seen=%0d k=%0d want 1/16", seen, k);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_rsp: got %b/%b/%h want 1000/1/0", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        eng_done = 1'b1;
        eng_rx_data = 32'h5555_AAAA;
        #1;
        n_checks++;
        if (eng_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_tie_abort: got %b want 0", eng_abort);
        end
        @(negedge clk);
        eng_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_data !== 32'h5555_AAAA) begin
            n_fail++;
            $display("FAIL timeout_tie_rsp: got %b/%b/%h want 0001/0/5555aaaa",
                     rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_wait();
        logic [3:0]  rdy, rv;
        logic        st, re;
        logic [1:0]  cs;
        logic [31:0] tx, rd;
        @(negedge clk);
        req_valid = 4'b0100;
        repeat (3) @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cs,
             eng_tx_data, eng_abort, busy} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: busy=%b cs=%0d tx=%h", busy, eng_cs, eng_tx_data);
        end
        rst_n = 1'b1;
        xfer(4'b1111, 32'h7777_0000, 2, rdy, st, cs, tx, rv, rd, re);
        req_valid = '0;
        n_checks++;
        if (rdy !== 4'b0001 || rv !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_grant: got %b/%b want 0001", rdy, rv);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_spurious_done();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
